rs_alu: RTL and testbench
=========================

Name: rs_alu

Overview:
- Reservation station for integer ALU and branch-compare ops in the Tomasulo core.
- Accepts issued ops from the dispatcher and holds them until both operands are known.
- Wakes operands by snooping both CDB broadcasts: the RS channel, i.e. its own results, and the LSB channel.
- Each cycle it dispatches one ready entry to an internal ALU and drives the registered RS-side CDB input: enable, label, value.

Parameters:
- RS_SIZE, 8, number of entries; power of two, at least 2.
- ID_WIDTH, 5, width of a ROB label (tag).
- VAL_WIDTH, 32, operand/result width.
- OP_WIDTH, 4, ALU opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_in  in  1  synchronous, active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush  in  1  misprediction flush.
- issue_en  in  1  issue valid this cycle.
- issue_op  in  OP_WIDTH  ALU opcode.
- issue_vj  in  VAL_WIDTH  operand j value.
- issue_qj  in  ID_WIDTH  operand j tag.
- issue_qj_busy  in  1  operand j waits on issue_qj.
- issue_vk  in  VAL_WIDTH  operand k value.
- issue_qk  in  ID_WIDTH  operand k tag.
- issue_qk_busy  in  1  operand k waits on issue_qk.
- issue_dest  in  ID_WIDTH  destination ROB label.
- rs_full  out  1  no free entry.
- cdb_rs_en  in  1  RS broadcast valid.
- cdb_rs_lab  in  ID_WIDTH  RS broadcast label.
- cdb_rs_val  in  VAL_WIDTH  RS broadcast value.
- cdb_lsb_en  in  1  LSB broadcast valid.
- cdb_lsb_lab  in  ID_WIDTH  LSB broadcast label.
- cdb_lsb_val  in  VAL_WIDTH  LSB broadcast value.
- rs_cdb_en_out  out  1  result valid.
- rs_cdb_lab_out  out  ID_WIDTH  result label.
- rs_cdb_val_out  out  VAL_WIDTH  result value.

Behaviour:
- Reset (rst_in=0 at an edge): all entries not busy; rs_cdb_en_out=0, rs_cdb_lab_out=0, rs_cdb_val_out=0; rs_full=0.
- Priority: reset > flush > rdy_in.
- Flush: same reset effect at the next edge; CDB and issue inputs in that cycle are ignored.
- rdy_in=0: all registers hold, outputs included; inputs are ignored.
- Per-entry state: busy, op, vj, qj, qj_busy, vk, qk, qk_busy, dest. Ready = busy & !qj_busy & !qk_busy.
- Issue:
  - Written into the lowest-index free entry, computed from current registered state.
  - An entry freed by dispatch in the same cycle is not reused until the next cycle.
  - issue_en while rs_full=1 is dropped (protocol violation; bench asserts it never happens).
- Issue-time forwarding: if issue_qj_busy and a CDB channel is valid with a matching label, store that value and clear qj_busy. Same rule for k.
- Wakeup: each busy waiting operand compares against both channels every cycle. On a match it captures the value and clears its busy flag at the edge. If both channels match, the LSB value wins (cannot occur legally; labels are unique).
- Dispatch: lowest-index ready entry is selected combinationally. The ALU result is registered into rs_cdb_*_out at the edge, and the entry's busy flag clears at that edge. rs_cdb_en_out is 0 in any cycle with no ready entry.
- Latency:
  - An entry issued with both operands ready at edge t is dispatchable in cycle t, so its result is visible after edge t+1.
  - A woken entry dispatches in the cycle after its wakeup edge.
- Back-to-back dependency: this block's own output feeds cdb_rs_* externally, so a dependent op dispatches one cycle after its producer's result is visible.
- rs_full: combinational AND of all busy bits.
- ALU opcodes, all VAL_WIDTH wrap-around arithmetic:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - SLL=5, SRL=6, SRA=7; shift amount is vk[4:0].
  - SLT=8, SLTU=9; result is 1 or 0.
  - EQ=10, NE=11, LT=12, GE=13, LTU=14, GEU=15; result is 1 or 0, used for branch resolution.

Decomposition:
- Shared include util.v holds ID_WIDTH, VAL_WIDTH, OP_WIDTH, RS_SIZE and the ALU opcode localparams.
- One combinational sub-module, rs_alu_unit (op, a, b -> result), instantiated once.
- Free-entry and ready-entry priority encoders stay inline.

Test Plan:
- Reset/idle: hold rst_in=0 two cycles, then release -> rs_full=0, rs_cdb_en_out=0, label 0, value 0.
- Ready issue: issue ADD vj=5, vk=7, dest=3, both operands ready -> one cycle later rs_cdb_en_out=1, lab=3, val=12, for exactly one cycle.
- Wakeup on LSB channel: issue SUB with qj=9 busy, vk=1, dest=4; two cycles later drive cdb_lsb_en=1, lab=9, val=10 -> the following cycle out lab=4, val=9. Also: an issue-time match on cdb_rs (lab=9 in the issue cycle) yields the same result one cycle earlier.
- Full and concurrency: issue 8 ops all waiting on tag 20 -> rs_full=1 and no output. Broadcast cdb_rs lab=20 -> results emerge one per cycle in index order 0..7; rs_full drops after the first dispatch edge, and a new issue in that cycle is accepted.
- Flush mid-operation: 3 waiting entries plus a valid output, assert flush -> next cycle all entries free and rs_cdb_en_out=0. A later broadcast of the old tags produces no output.
- Ops and freeze: SRA vj=0x80000000, vk=0x24 -> 0xF8000000. SLTU vj=1, vk=0xFFFFFFFF -> 1. With rdy_in=0 for 3 cycles, outputs hold their values.

Source files
------------

// File: rtl/rs_alu_pkg.sv
// Shared sizing defaults and ALU opcode encodings for the integer reservation station.
package rs_alu_pkg;

    localparam int DEF_RS_SIZE   = 8;
    localparam int DEF_ID_WIDTH  = 5;
    localparam int DEF_VAL_WIDTH = 32;
    localparam int DEF_OP_WIDTH  = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_EQ   = 4'd10,
        OP_NE   = 4'd11,
        OP_LT   = 4'd12,
        OP_GE   = 4'd13,
        OP_LTU  = 4'd14,
        OP_GEU  = 4'd15
    } alu_op_e;

endpackage

// File: rtl/rs_alu_unit.sv
// Combinational integer ALU: arithmetic, logic, shifts and compare/branch predicates.
module rs_alu_unit
    import rs_alu_pkg::*;
#(
    parameter int VAL_WIDTH = DEF_VAL_WIDTH,
    parameter int OP_WIDTH  = DEF_OP_WIDTH
) (
    input  logic [OP_WIDTH-1:0]  op,
    input  logic [VAL_WIDTH-1:0] a,
    input  logic [VAL_WIDTH-1:0] b,
    output logic [VAL_WIDTH-1:0] result
);

    logic [VAL_WIDTH-1:0] result_s;
    logic [4:0]           shamt_s;

    // Zero-extends a predicate bit to a full-width result.
    function automatic logic [VAL_WIDTH-1:0] flag(input logic bit_in);
        flag = {{(VAL_WIDTH-1){1'b0}}, bit_in};
    endfunction

    // Opcode decode and evaluation.
    always_comb begin
        result_s = '0;
        shamt_s  = b[4:0];
        case (op[3:0])
            OP_ADD:  result_s = a + b;
            OP_SUB:  result_s = a - b;
            OP_AND:  result_s = a & b;
            OP_OR:   result_s = a | b;
            OP_XOR:  result_s = a ^ b;
            OP_SLL:  result_s = a << shamt_s;
            OP_SRL:  result_s = a >> shamt_s;
            OP_SRA:  result_s = VAL_WIDTH'($signed(a) >>> shamt_s);
            OP_SLT:  result_s = flag($signed(a) < $signed(b));
            OP_SLTU: result_s = flag(a < b);
            OP_EQ:   result_s = flag(a == b);
            OP_NE:   result_s = flag(a != b);
            OP_LT:   result_s = flag($signed(a) < $signed(b));
            OP_GE:   result_s = flag($signed(a) >= $signed(b));
            OP_LTU:  result_s = flag(a < b);
            OP_GEU:  result_s = flag(a >= b);
            default: result_s = '0;
        endcase
    end

    assign result = result_s;

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds issued ops until both operands are known, snoops
// both CDB channels for wakeup and dispatches one ready entry per cycle.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE   = DEF_RS_SIZE,
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int VAL_WIDTH = DEF_VAL_WIDTH,
    parameter int OP_WIDTH  = DEF_OP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 issue_en,
    input  logic [OP_WIDTH-1:0]  issue_op,
    input  logic [VAL_WIDTH-1:0] issue_vj,
    input  logic [ID_WIDTH-1:0]  issue_qj,
    input  logic                 issue_qj_busy,
    input  logic [VAL_WIDTH-1:0] issue_vk,
    input  logic [ID_WIDTH-1:0]  issue_qk,
    input  logic                 issue_qk_busy,
    input  logic [ID_WIDTH-1:0]  issue_dest,
    output logic                 rs_full,
    input  logic                 cdb_rs_en,
    input  logic [ID_WIDTH-1:0]  cdb_rs_lab,
    input  logic [VAL_WIDTH-1:0] cdb_rs_val,
    input  logic                 cdb_lsb_en,
    input  logic [ID_WIDTH-1:0]  cdb_lsb_lab,
    input  logic [VAL_WIDTH-1:0] cdb_lsb_val,
    output logic                 rs_cdb_en_out,
    output logic [ID_WIDTH-1:0]  rs_cdb_lab_out,
    output logic [VAL_WIDTH-1:0] rs_cdb_val_out
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]   busy_r;
    logic [RS_SIZE-1:0]   qj_busy_r;
    logic [RS_SIZE-1:0]   qk_busy_r;
    logic [OP_WIDTH-1:0]  op_r   [RS_SIZE];
    logic [VAL_WIDTH-1:0] vj_r   [RS_SIZE];
    logic [VAL_WIDTH-1:0] vk_r   [RS_SIZE];
    logic [ID_WIDTH-1:0]  qj_r   [RS_SIZE];
    logic [ID_WIDTH-1:0]  qk_r   [RS_SIZE];
    logic [ID_WIDTH-1:0]  dest_r [RS_SIZE];

    logic                 cdb_en_r;
    logic [ID_WIDTH-1:0]  cdb_lab_r;
    logic [VAL_WIDTH-1:0] cdb_val_r;

    logic [RS_SIZE-1:0]   ready_vec_s;
    logic                 ready_any_s;
    logic [IDX_W-1:0]     ready_idx_s;
    logic [IDX_W-1:0]     free_idx_s;
    logic                 full_s;
    logic [VAL_WIDTH-1:0] alu_result_s;
    logic [VAL_WIDTH-1:0] fwd_vj_s;
    logic                 fwd_qj_busy_s;
    logic [VAL_WIDTH-1:0] fwd_vk_s;
    logic                 fwd_qk_busy_s;

    // Lowest set bit of a per-entry vector; shared by the free and ready encoders.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [RS_SIZE-1:0] v);
        lowest_set = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = IDX_W'(i);
            end
        end
    endfunction

    assign ready_vec_s = busy_r & ~qj_busy_r & ~qk_busy_r;
    assign ready_any_s = |ready_vec_s;
    assign ready_idx_s = lowest_set(ready_vec_s);
    assign free_idx_s  = lowest_set(~busy_r);
    assign full_s      = &busy_r;

    rs_alu_unit #(
        .VAL_WIDTH (VAL_WIDTH),
        .OP_WIDTH  (OP_WIDTH)
    ) u_alu (
        .op     (op_r[ready_idx_s]),
        .a      (vj_r[ready_idx_s]),
        .b      (vk_r[ready_idx_s]),
        .result (alu_result_s)
    );

    // Issue-time forwarding: an operand broadcast in the issue cycle is captured directly.
    always_comb begin
        fwd_vj_s      = issue_vj;
        fwd_qj_busy_s = issue_qj_busy;
        fwd_vk_s      = issue_vk;
        fwd_qk_busy_s = issue_qk_busy;
        if (issue_qj_busy && cdb_lsb_en && (cdb_lsb_lab == issue_qj)) begin
            fwd_vj_s      = cdb_lsb_val;
            fwd_qj_busy_s = 1'b0;
        end else if (issue_qj_busy && cdb_rs_en && (cdb_rs_lab == issue_qj)) begin
            fwd_vj_s      = cdb_rs_val;
            fwd_qj_busy_s = 1'b0;
        end else begin
            fwd_vj_s      = issue_vj;
            fwd_qj_busy_s = issue_qj_busy;
        end
        if (issue_qk_busy && cdb_lsb_en && (cdb_lsb_lab == issue_qk)) begin
            fwd_vk_s      = cdb_lsb_val;
            fwd_qk_busy_s = 1'b0;
        end else if (issue_qk_busy && cdb_rs_en && (cdb_rs_lab == issue_qk)) begin
            fwd_vk_s      = cdb_rs_val;
            fwd_qk_busy_s = 1'b0;
        end else begin
            fwd_vk_s      = issue_vk;
            fwd_qk_busy_s = issue_qk_busy;
        end
    end

    // Entry state, wakeup, dispatch and registered CDB output.
    always_ff @(posedge clk) begin
        if (!rst_in || flush) begin
            busy_r    <= '0;
            qj_busy_r <= '0;
            qk_busy_r <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]   <= '0;
                vj_r[i]   <= '0;
                vk_r[i]   <= '0;
                qj_r[i]   <= '0;
                qk_r[i]   <= '0;
                dest_r[i] <= '0;
            end
            cdb_en_r  <= 1'b0;
            cdb_lab_r <= '0;
            cdb_val_r <= '0;
        end else if (rdy_in) begin
            // LSB checked first so it takes precedence on a (not legal) double match.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_r[i] && qj_busy_r[i]) begin
                    if (cdb_lsb_en && (cdb_lsb_lab == qj_r[i])) begin
                        vj_r[i]      <= cdb_lsb_val;
                        qj_busy_r[i] <= 1'b0;
                    end else if (cdb_rs_en && (cdb_rs_lab == qj_r[i])) begin
                        vj_r[i]      <= cdb_rs_val;
                        qj_busy_r[i] <= 1'b0;
                    end
                end
                if (busy_r[i] && qk_busy_r[i]) begin
                    if (cdb_lsb_en && (cdb_lsb_lab == qk_r[i])) begin
                        vk_r[i]      <= cdb_lsb_val;
                        qk_busy_r[i] <= 1'b0;
                    end else if (cdb_rs_en && (cdb_rs_lab == qk_r[i])) begin
                        vk_r[i]      <= cdb_rs_val;
                        qk_busy_r[i] <= 1'b0;
                    end
                end
            end

            if (ready_any_s) begin
                busy_r[ready_idx_s] <= 1'b0;
                cdb_en_r            <= 1'b1;
                cdb_lab_r           <= dest_r[ready_idx_s];
                cdb_val_r           <= alu_result_s;
            end else begin
                cdb_en_r <= 1'b0;
            end

            // The free slot is never the dispatched one, so a slot freed this edge waits a cycle.
            if (issue_en && !full_s) begin
                busy_r[free_idx_s]    <= 1'b1;
                op_r[free_idx_s]      <= issue_op;
                vj_r[free_idx_s]      <= fwd_vj_s;
                qj_r[free_idx_s]      <= issue_qj;
                qj_busy_r[free_idx_s] <= fwd_qj_busy_s;
                vk_r[free_idx_s]      <= fwd_vk_s;
                qk_r[free_idx_s]      <= issue_qk;
                qk_busy_r[free_idx_s] <= fwd_qk_busy_s;
                dest_r[free_idx_s]    <= issue_dest;
            end
        end
    end

    assign rs_full        = full_s;
    assign rs_cdb_en_out  = cdb_en_r;
    assign rs_cdb_lab_out = cdb_lab_r;
    assign rs_cdb_val_out = cdb_val_r;

endmodule

// File: tb/tb_rs_alu.sv
// Directed self-checking bench for rs_alu with hand-computed expected results.
module tb_rs_alu;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        issue_en;
    logic [3:0]  issue_op;
    logic [31:0] issue_vj;
    logic [4:0]  issue_qj;
    logic        issue_qj_busy;
    logic [31:0] issue_vk;
    logic [4:0]  issue_qk;
    logic        issue_qk_busy;
    logic [4:0]  issue_dest;
    logic        rs_full;
    logic        cdb_rs_en;
    logic [4:0]  cdb_rs_lab;
    logic [31:0] cdb_rs_val;
    logic        cdb_lsb_en;
    logic [4:0]  cdb_lsb_lab;
    logic [31:0] cdb_lsb_val;
    logic        rs_cdb_en_out;
    logic [4:0]  rs_cdb_lab_out;
    logic [31:0] rs_cdb_val_out;

    int total;
    int bad;

    rs_alu dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush          (flush),
        .issue_en       (issue_en),
        .issue_op       (issue_op),
        .issue_vj       (issue_vj),
        .issue_qj       (issue_qj),
        .issue_qj_busy  (issue_qj_busy),
        .issue_vk       (issue_vk),
        .issue_qk       (issue_qk),
        .issue_qk_busy  (issue_qk_busy),
        .issue_dest     (issue_dest),
        .rs_full        (rs_full),
        .cdb_rs_en      (cdb_rs_en),
        .cdb_rs_lab     (cdb_rs_lab),
        .cdb_rs_val     (cdb_rs_val),
        .cdb_lsb_en     (cdb_lsb_en),
        .cdb_lsb_lab    (cdb_lsb_lab),
        .cdb_lsb_val    (cdb_lsb_val),
        .rs_cdb_en_out  (rs_cdb_en_out),
        .rs_cdb_lab_out (rs_cdb_lab_out),
        .rs_cdb_val_out (rs_cdb_val_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_set(input logic [3:0] op, input logic [31:0] vj, input logic [4:0] qj,
                             input logic qjb, input logic [31:0] vk, input logic [4:0] qk,
                             input logic qkb, input logic [4:0] dest);
        issue_en      = 1'b1;
        issue_op      = op;
        issue_vj      = vj;
        issue_qj      = qj;
        issue_qj_busy = qjb;
        issue_vk      = vk;
        issue_qk      = qk;
        issue_qk_busy = qkb;
        issue_dest    = dest;
    endtask

    task automatic issue_clr();
        issue_en      = 1'b0;
        issue_qj_busy = 1'b0;
        issue_qk_busy = 1'b0;
    endtask

    task automatic cdb_clr();
        cdb_rs_en  = 1'b0;
        cdb_lsb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        total++;
        if ({rs_full, rs_cdb_en_out} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags: got full=%0b en=%0b want 0 0", rs_full, rs_cdb_en_out);
        end
        total++;
        if ({rs_cdb_lab_out, rs_cdb_val_out} !== 37'd0) begin
            bad++;
            $display("FAIL reset_data: got lab=%0d val=%h want 0 0", rs_cdb_lab_out, rs_cdb_val_out);
        end
    endtask

    task automatic test_ready_issue();
        issue_set(4'd0, 32'd5, 5'd0, 1'b0, 32'd7, 5'd0, 1'b0, 5'd3);
        tick();
        issue_clr();
        total++;
        if (rs_cdb_en_out !== 1'b0) begin
            bad++;
            $display("FAIL ready_early: got en=%0b want 0", rs_cdb_en_out);
        end
        tick();
        total++;
        if ({rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== {1'b1, 5'd3, 32'd12}) begin
            bad++;
            $display("FAIL ready_result: got en=%0b lab=%0d val=%0d want 1 3 12",
                     rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out);
        end
        tick();
        total++;
        if (rs_cdb_en_out !== 1'b0) begin
            bad++;
            $display("FAIL ready_once: got en=%0b want 0", rs_cdb_en_out);
        end
    endtask

    task automatic test_wakeup();
        issue_set(4'd1, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0, 1'b0, 5'd4);
        tick();
        issue_clr();
        tick();
        total++;
        if (rs_cdb_en_out !== 1'b0) begin
            bad++;
            $display("FAIL wake_wait: got en=%0b want 0", rs_cdb_en_out);
        end
        cdb_lsb_en  = 1'b1;
        cdb_lsb_lab = 5'd9;
        cdb_lsb_val = 32'd10;
        tick();
        cdb_clr();
        total++;
        if (rs_cdb_en_out !== 1'b0) begin
            bad++;
            $display("FAIL wake_edge: got en=%0b want 0", rs_cdb_en_out);
        end
        tick();
        total++;
        if ({rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== {1'b1, 5'd4, 32'd9}) begin
            bad++;
            $display("FAIL wake_lsb: got en=%0b lab=%0d val=%0d want 1 4 9",
                     rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out);
        end
        tick();
        // Forwarded at issue from the RS channel: one cycle sooner.
        issue_set(4'd1, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0, 1'b0, 5'd4);
        cdb_rs_en  = 1'b1;
        cdb_rs_lab = 5'd9;
        cdb_rs_val = 32'd10;
        tick();
        issue_clr();
        cdb_clr();
        tick();
        total++;
        if ({rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== {1'b1, 5'd4, 32'd9}) begin
            bad++;
            $display("FAIL wake_fwd: got en=%0b lab=%0d val=%0d want 1 4 9",
                     rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out);
        end
        tick();
    endtask

    task automatic test_full_concurrency();
        for (int i = 0; i < 8; i++) begin
            issue_set(4'd0, 32'd0, 5'd20, 1'b1, 32'(i), 5'd0, 1'b0, 5'(10 + i));
            tick();
        end
        issue_clr();
        total++;
        if ({rs_full, rs_cdb_en_out} !== 2'b10) begin
            bad++;
            $display("FAIL full_set: got full=%0b en=%0b want 1 0", rs_full, rs_cdb_en_out);
        end
        cdb_rs_en  = 1'b1;
        cdb_rs_lab = 5'd20;
        cdb_rs_val = 32'd100;
        tick();
        cdb_clr();
        total++;
        if ({rs_full, rs_cdb_en_out} !== 2'b10) begin
            bad++;
            $display("FAIL full_woken: got full=%0b en=%0b want 1 0", rs_full, rs_cdb_en_out);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            issue_clr();
            total++;
            if ({rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== {1'b1, 5'(10 + i), 32'(100 + i)}) begin
                bad++;
                $display("FAIL drain_%0d: got en=%0b lab=%0d val=%0d want 1 %0d %0d",
                         i, rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out, 10 + i, 100 + i);
            end
            if (i == 0) begin
                total++;
                if (rs_full !== 1'b0) begin
                    bad++;
                    $display("FAIL full_drop: got full=%0b want 0", rs_full);
                end
                // Refill slot 0 with a waiting op so the drain order stays 0..7.
                issue_set(4'd0, 32'd0, 5'd25, 1'b1, 32'd5, 5'd0, 1'b0, 5'd30);
            end
        end
        tick();
        total++;
        if (rs_cdb_en_out !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle: got en=%0b want 0", rs_cdb_en_out);
        end
        cdb_lsb_en  = 1'b1;
        cdb_lsb_lab = 5'd25;
        cdb_lsb_val = 32'd7;
        tick();
        cdb_clr();
        tick();
        total++;
        if ({rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== {1'b1, 5'd30, 32'd12}) begin
            bad++;
            $display("FAIL refill_issue: got en=%0b lab=%0d val=%0d want 1 30 12",
                     rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            issue_set(4'd0, 32'd0, 5'd21, 1'b1, 32'd1, 5'd0, 1'b0, 5'(1 + i));
            tick();
        end
        issue_set(4'd0, 32'd2, 5'd0, 1'b0, 32'd2, 5'd0, 1'b0, 5'd5);
        tick();
        issue_clr();
        tick();
        total++;
        if ({rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== {1'b1, 5'd5, 32'd4}) begin
            bad++;
            $display("FAIL flush_pre: got en=%0b lab=%0d val=%0d want 1 5 4",
                     rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out);
        end
        flush = 1'b1;
        issue_set(4'd0, 32'd1, 5'd0, 1'b0, 32'd1, 5'd0, 1'b0, 5'd6);
        tick();
        flush = 1'b0;
        issue_clr();
        total++;
        if ({rs_full, rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== 39'd0) begin
            bad++;
            $display("FAIL flush_clear: got full=%0b en=%0b lab=%0d val=%0d want 0 0 0 0",
                     rs_full, rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out);
        end
        cdb_rs_en  = 1'b1;
        cdb_rs_lab = 5'd21;
        cdb_rs_val = 32'd50;
        tick();
        cdb_clr();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (rs_cdb_en_out !== 1'b0) begin
                bad++;
                $display("FAIL flush_stale_%0d: got en=%0b want 0", i, rs_cdb_en_out);
            end
        end
    endtask

    task automatic test_ops_and_freeze();
        logic [3:0]  ops [15];
        logic [31:0] as  [15];
        logic [31:0] bs  [15];
        logic [31:0] exp [15];
        ops = '{4'd7, 4'd9, 4'd1, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd11, 4'd15, 4'd13, 4'd12, 4'd3, 4'd2, 4'd14};
        as  = '{32'h8000_0000, 32'd1, 32'd3, 32'h0000_F0F0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'd7, 32'd7, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'hA, 32'hC, 32'h8000_0000};
        bs  = '{32'h24, 32'hFFFF_FFFF, 32'd5, 32'h0000_0FF0, 32'h21, 32'd31, 32'd1,
                32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'h5, 32'hA, 32'd0};
        exp = '{32'hF800_0000, 32'd1, 32'hFFFF_FFFE, 32'h0000_FF00, 32'd2, 32'd1, 32'd1,
                32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'hF, 32'h8, 32'd0};
        for (int i = 0; i < 15; i++) begin
            issue_set(ops[i], as[i], 5'd0, 1'b0, bs[i], 5'd0, 1'b0, 5'(i + 1));
            tick();
            issue_clr();
            tick();
            total++;
            if ({rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== {1'b1, 5'(i + 1), exp[i]}) begin
                bad++;
                $display("FAIL op_%0d: got en=%0b lab=%0d val=%h want 1 %0d %h",
                         ops[i], rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out, i + 1, exp[i]);
            end
            if (i == 1) begin
                // Output of SLTU is held while frozen; issue and CDB are ignored.
                rdy_in = 1'b0;
                issue_set(4'd0, 32'd1, 5'd0, 1'b0, 32'd1, 5'd0, 1'b0, 5'd9);
                cdb_rs_en  = 1'b1;
                cdb_rs_lab = 5'd0;
                cdb_rs_val = 32'd3;
                for (int f = 0; f < 3; f++) begin
                    tick();
                    total++;
                    if ({rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out} !== {1'b1, 5'd2, 32'd1}) begin
                        bad++;
                        $display("FAIL freeze_%0d: got en=%0b lab=%0d val=%0d want 1 2 1",
                                 f, rs_cdb_en_out, rs_cdb_lab_out, rs_cdb_val_out);
                    end
                end
                rdy_in = 1'b1;
                issue_clr();
                cdb_clr();
                tick();
                total++;
                if ({rs_full, rs_cdb_en_out} !== 2'b00) begin
                    bad++;
                    $display("FAIL freeze_drop: got full=%0b en=%0b want 0 0", rs_full, rs_cdb_en_out);
                end
            end
        end
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        flush         = 1'b0;
        issue_en      = 1'b0;
        issue_op      = 4'd0;
        issue_vj      = 32'd0;
        issue_qj      = 5'd0;
        issue_qj_busy = 1'b0;
        issue_vk      = 32'd0;
        issue_qk      = 5'd0;
        issue_qk_busy = 1'b0;
        issue_dest    = 5'd0;
        cdb_rs_en     = 1'b0;
        cdb_rs_lab    = 5'd0;
        cdb_rs_val    = 32'd0;
        cdb_lsb_en    = 1'b0;
        cdb_lsb_lab   = 5'd0;
        cdb_lsb_val   = 32'd0;
        #2;
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_full_concurrency();
        test_flush();
        test_ops_and_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
